// File: rtl/spi_apb_arbiter.sv
// Two-requester APB arbiter in front of one shared SPI APB slave.
// Round-robin grant, registered slave request, ACCESS-phase timeout with a drain phase.
module spi_apb_arbiter #(
    parameter logic [11:0] TIMEOUT_CYCLES = 12'd4095
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_psel,
    input  logic        m0_penable,
    input  logic        m0_pwrite,
    input  logic [31:0] m0_paddr,
    input  logic [31:0] m0_pwdata,
    input  logic [3:0]  m0_pstrb,
    input  logic [2:0]  m0_pprot,
    output logic        m0_pready,
    output logic        m0_pslverr,
    output logic [31:0] m0_prdata,

    input  logic        m1_psel,
    input  logic        m1_penable,
    input  logic        m1_pwrite,
    input  logic [31:0] m1_paddr,
    input  logic [31:0] m1_pwdata,
    input  logic [3:0]  m1_pstrb,
    input  logic [2:0]  m1_pprot,
    output logic        m1_pready,
    output logic        m1_pslverr,
    output logic [31:0] m1_prdata,

    output logic        s_psel,
    output logic        s_penable,
    output logic        s_pwrite,
    output logic [31:0] s_paddr,
    output logic [31:0] s_pwdata,
    output logic [3:0]  s_pstrb,
    output logic [2:0]  s_pprot,
    input  logic        s_pready,
    input  logic        s_pslverr,
    input  logic [31:0] s_prdata,

    output logic        arb_timeout
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RESP, DRAIN} state_t;

    state_t      state;
    logic        grant;        // 0 = m0 owns the current transfer, 1 = m1
    logic        last_grant;
    logic [11:0] timeout_cnt;

    logic pick_m1;
    logic timeout_hit;
    logic unused_inputs;

    // On a tie the requester that was not served last wins.
    assign pick_m1     = m1_psel & (~m0_psel | ~last_grant);
    assign timeout_hit = (TIMEOUT_CYCLES != 12'd0) && (timeout_cnt == TIMEOUT_CYCLES - 12'd1);

    // Requester penable carries no information once psel has been registered.
    assign unused_inputs = m0_penable ^ m1_penable;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b1;
            timeout_cnt <= 12'd0;
            s_psel      <= 1'b0;
            s_penable   <= 1'b0;
            s_pwrite    <= 1'b0;
            s_paddr     <= 32'd0;
            s_pwdata    <= 32'd0;
            s_pstrb     <= 4'd0;
            s_pprot     <= 3'd0;
            m0_pready   <= 1'b0;
            m0_pslverr  <= 1'b0;
            m0_prdata   <= 32'd0;
            m1_pready   <= 1'b0;
            m1_pslverr  <= 1'b0;
            m1_prdata   <= 32'd0;
            arb_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults here make every response output a single-cycle pulse;
            // later assignments in the case arms override them for this edge only.
            m0_pready   <= 1'b0;
            m0_pslverr  <= 1'b0;
            m0_prdata   <= 32'd0;
            m1_pready   <= 1'b0;
            m1_pslverr  <= 1'b0;
            m1_prdata   <= 32'd0;
            arb_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    if (m0_psel || m1_psel) begin
                        grant      <= pick_m1;
                        last_grant <= pick_m1;
                        s_pwrite   <= pick_m1 ? m1_pwrite : m0_pwrite;
                        s_paddr    <= pick_m1 ? m1_paddr  : m0_paddr;
                        s_pwdata   <= pick_m1 ? m1_pwdata : m0_pwdata;
                        s_pstrb    <= pick_m1 ? m1_pstrb  : m0_pstrb;
                        s_pprot    <= pick_m1 ? m1_pprot  : m0_pprot;
                        s_psel     <= 1'b1;
                        s_penable  <= 1'b0;
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    s_penable   <= 1'b1;
                    timeout_cnt <= 12'd0;
                    state       <= ACCESS;
                end

                ACCESS: begin
                    // A slave completion in the expiry cycle takes priority over the timeout.
                    if (s_pready) begin
                        s_psel    <= 1'b0;
                        s_penable <= 1'b0;
                        if (grant) begin
                            m1_pready  <= 1'b1;
                            m1_prdata  <= s_prdata;
                            m1_pslverr <= s_pslverr;
                        end else begin
                            m0_pready  <= 1'b1;
                            m0_prdata  <= s_prdata;
                            m0_pslverr <= s_pslverr;
                        end
                        state <= RESP;
                    end else if (timeout_hit) begin
                        if (grant) begin
                            m1_pready  <= 1'b1;
                            m1_pslverr <= 1'b1;
                        end else begin
                            m0_pready  <= 1'b1;
                            m0_pslverr <= 1'b1;
                        end
                        arb_timeout <= 1'b1;
                        timeout_cnt <= 12'd0;
                        state       <= DRAIN;
                    end else begin
                        timeout_cnt <= timeout_cnt + 12'd1;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                DRAIN: begin
                    // The slave is still mid-transfer; hold the bus and discard its late answer.
                    if (s_pready) begin
                        s_psel    <= 1'b0;
                        s_penable <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    s_psel    <= 1'b0;
                    s_penable <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Scoreboard bench for spi_apb_arbiter: expected grants and responses are queued
// as stimulus is driven and compared by a monitor when the DUT produces them.
module tb_spi_apb_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
    } grant_t;

    typedef struct {
        int          who;
        logic [31:0] data;
        logic        err;
        logic        to;
    } resp_t;

    typedef struct {
        int          wait_n;
        logic [31:0] data;
        logic        err;
    } slv_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m0_psel = 1'b0, m0_penable = 1'b0, m0_pwrite = 1'b0;
    logic [31:0] m0_paddr = 32'd0, m0_pwdata = 32'd0;
    logic [3:0]  m0_pstrb = 4'd0;
    logic [2:0]  m0_pprot = 3'd0;
    logic        m0_pready, m0_pslverr;
    logic [31:0] m0_prdata;

    logic        m1_psel = 1'b0, m1_penable = 1'b0, m1_pwrite = 1'b0;
    logic [31:0] m1_paddr = 32'd0, m1_pwdata = 32'd0;
    logic [3:0]  m1_pstrb = 4'd0;
    logic [2:0]  m1_pprot = 3'd0;
    logic        m1_pready, m1_pslverr;
    logic [31:0] m1_prdata;

    logic        s_psel, s_penable, s_pwrite;
    logic [31:0] s_paddr, s_pwdata;
    logic [3:0]  s_pstrb;
    logic [2:0]  s_pprot;
    logic        s_pready = 1'b0, s_pslverr = 1'b0;
    logic [31:0] s_prdata = 32'd0;
    logic        arb_timeout;

    int checks = 0;
    int errors = 0;

    grant_t exp_grant[$];
    resp_t  exp_resp[$];
    slv_t   slv_q[$];

    spi_apb_arbiter #(.TIMEOUT_CYCLES(12'd8)) dut (
        .clock(clk), .reset(rst_n),
        .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb), .m0_pprot(m0_pprot),
        .m0_pready(m0_pready), .m0_pslverr(m0_pslverr), .m0_prdata(m0_prdata),
        .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb), .m1_pprot(m1_pprot),
        .m1_pready(m1_pready), .m1_pslverr(m1_pslverr), .m1_prdata(m1_prdata),
        .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
        .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb), .s_pprot(s_pprot),
        .s_pready(s_pready), .s_pslverr(s_pslverr), .s_prdata(s_prdata),
        .arb_timeout(arb_timeout)
    );

    // Slave model: each transfer takes its behaviour from slv_q when ACCESS begins.
    slv_t slv_cur = '{wait_n: 0, data: 32'd0, err: 1'b0};
    int   acc_cnt = 0;
    always @(negedge clk) begin
        if (s_psel && s_penable) begin
            if (acc_cnt == 0) begin
                if (slv_q.size() > 0) slv_cur = slv_q.pop_front();
                else slv_cur = '{wait_n: 0, data: 32'd0, err: 1'b0};
            end
            if (acc_cnt == slv_cur.wait_n) begin
                s_pready  = 1'b1;
                s_prdata  = slv_cur.data;
                s_pslverr = slv_cur.err;
            end else begin
                s_pready  = 1'b0;
                s_prdata  = 32'd0;
                s_pslverr = 1'b0;
            end
            acc_cnt++;
        end else begin
            acc_cnt   = 0;
            s_pready  = 1'b0;
            s_prdata  = 32'd0;
            s_pslverr = 1'b0;
        end
    end

    // Monitor: grants are checked in the SETUP cycle, responses whenever a pready appears.
    grant_t      mg;
    resp_t       mr;
    logic [68:0] act_v, exp_v;
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_psel && !s_penable) begin
                checks++;
                if (exp_grant.size() == 0) begin
                    errors++;
                    $display("FAIL grant_unexpected addr=%h expected no grant", s_paddr);
                end else begin
                    mg = exp_grant.pop_front();
                    if ({s_paddr, s_pwrite, s_pwdata, s_pstrb, s_pprot} !==
                        {mg.addr, mg.write, mg.wdata, mg.strb, mg.prot}) begin
                        errors++;
                        $display("FAIL grant got addr=%h wr=%b wdata=%h strb=%h prot=%h expected addr=%h wr=%b wdata=%h strb=%h prot=%h",
                                 s_paddr, s_pwrite, s_pwdata, s_pstrb, s_pprot,
                                 mg.addr, mg.write, mg.wdata, mg.strb, mg.prot);
                    end
                end
            end
            act_v = {m0_pready, m0_pslverr, m0_prdata, m1_pready, m1_pslverr, m1_prdata, arb_timeout};
            if (m0_pready || m1_pready) begin
                checks++;
                if (exp_resp.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected got %h expected none", act_v);
                end else begin
                    mr = exp_resp.pop_front();
                    if (mr.who == 0) exp_v = {1'b1, mr.err, mr.data, 1'b0, 1'b0, 32'd0, mr.to};
                    else             exp_v = {1'b0, 1'b0, 32'd0, 1'b1, mr.err, mr.data, mr.to};
                    if (act_v !== exp_v) begin
                        errors++;
                        $display("FAIL resp got %h expected %h", act_v, exp_v);
                    end
                end
            end else begin
                checks++;
                if (act_v !== 69'd0) begin
                    errors++;
                    $display("FAIL quiet_outputs got %h expected 0", act_v);
                end
            end
        end
    end

    task automatic wait_pready(input int who, input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!((who == 0) ? m0_pready : m1_pready) && cyc < max_cyc);
    endtask

    task automatic test_reset();
        m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 32'h3000_0000; m0_pwdata = 32'h0;
        m0_pstrb = 4'hF; m0_pprot = 3'd0;
        m1_psel = 1'b1; m1_pwrite = 1'b1; m1_paddr = 32'h1000_0000; m1_pwdata = 32'h1111_2222;
        m1_pstrb = 4'h3; m1_pprot = 3'd2;
        repeat (3) @(negedge clk);
        checks++;
        if ({m0_pready, m0_pslverr, m0_prdata} !== 34'd0) begin
            errors++; $display("FAIL reset_m0 got %h expected 0", {m0_pready, m0_pslverr, m0_prdata});
        end
        checks++;
        if ({m1_pready, m1_pslverr, m1_prdata} !== 34'd0) begin
            errors++; $display("FAIL reset_m1 got %h expected 0", {m1_pready, m1_pslverr, m1_prdata});
        end
        checks++;
        if ({s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb, s_pprot, arb_timeout} !== 75'd0) begin
            errors++;
            $display("FAIL reset_slave got %h expected 0",
                     {s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb, s_pprot, arb_timeout});
        end
    endtask

    task automatic test_round_robin();
        int n = 0;
        int k = 0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) exp_grant.push_back('{32'h3000_0000, 1'b0, 32'h0, 4'hF, 3'd0});
            else            exp_grant.push_back('{32'h1000_0000, 1'b1, 32'h1111_2222, 4'h3, 3'd2});
            slv_q.push_back('{wait_n: i % 3, data: 32'hC0DE_0000 + i, err: 1'b0});
            exp_resp.push_back('{who: i % 2, data: 32'hC0DE_0000 + i, err: 1'b0, to: 1'b0});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({s_psel, s_penable, s_paddr} !== {1'b1, 1'b0, 32'h3000_0000}) begin
            errors++;
            $display("FAIL first_edge_grant got psel=%b pen=%b addr=%h expected 1 0 30000000",
                     s_psel, s_penable, s_paddr);
        end
        while (n < 4 && k < 100) begin
            @(negedge clk);
            k++;
            if (m0_pready || m1_pready) n++;
        end
        m0_psel = 1'b0;
        m1_psel = 1'b0;
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL rr_count got %0d expected 4", n);
        end
    endtask

    task automatic test_single_read();
        int c;
        m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 32'h3000_0100; m0_pwdata = 32'h0;
        m0_pstrb = 4'hF; m0_pprot = 3'd1;
        exp_grant.push_back('{32'h3000_0100, 1'b0, 32'h0, 4'hF, 3'd1});
        slv_q.push_back('{wait_n: 3, data: 32'hDEAD_BEEF, err: 1'b0});
        exp_resp.push_back('{who: 0, data: 32'hDEAD_BEEF, err: 1'b0, to: 1'b0});
        wait_pready(0, 40, c);
        m0_psel = 1'b0;
        checks++;
        if (c != 6) begin
            errors++; $display("FAIL single_latency got %0d expected 6", c);
        end
        @(negedge clk);
        checks++;
        if (m0_pready !== 1'b0) begin
            errors++; $display("FAIL single_pulse got %b expected 0", m0_pready);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        int g = 0;
        m0_psel = 1'b1; m0_pwrite = 1'b1; m0_paddr = 32'h3000_0200; m0_pwdata = 32'h0000_00AA;
        m0_pstrb = 4'h1; m0_pprot = 3'd0;
        exp_grant.push_back('{32'h3000_0200, 1'b1, 32'h0000_00AA, 4'h1, 3'd0});
        exp_grant.push_back('{32'h3000_0204, 1'b0, 32'h0000_00AA, 4'hF, 3'd0});
        slv_q.push_back('{wait_n: 0, data: 32'h0, err: 1'b0});
        slv_q.push_back('{wait_n: 1, data: 32'h5555_AAAA, err: 1'b0});
        exp_resp.push_back('{who: 0, data: 32'h0, err: 1'b0, to: 1'b0});
        exp_resp.push_back('{who: 0, data: 32'h5555_AAAA, err: 1'b0, to: 1'b0});
        wait_pready(0, 40, c);
        checks++;
        if (c != 3) begin
            errors++; $display("FAIL b2b_min_latency got %0d expected 3", c);
        end
        m0_pwrite = 1'b0; m0_paddr = 32'h3000_0204; m0_pstrb = 4'hF;
        do begin
            @(negedge clk);
            g++;
        end while (!(s_psel && !s_penable) && g < 10);
        checks++;
        if (g != 2) begin
            errors++; $display("FAIL b2b_regrant_gap got %0d expected 2", g);
        end
        wait_pready(0, 40, c);
        m0_psel = 1'b0;
        checks++;
        if (c != 3) begin
            errors++; $display("FAIL b2b_second_latency got %0d expected 3", c);
        end
    endtask

    task automatic test_timeout();
        int c;
        int d = 1;
        m1_psel = 1'b1; m1_pwrite = 1'b1; m1_paddr = 32'h1000_0004; m1_pwdata = 32'hCAFE_F00D;
        m1_pstrb = 4'hF; m1_pprot = 3'd0;
        exp_grant.push_back('{32'h1000_0004, 1'b1, 32'hCAFE_F00D, 4'hF, 3'd0});
        exp_grant.push_back('{32'h3000_0300, 1'b0, 32'h0, 4'hF, 3'd0});
        slv_q.push_back('{wait_n: 20, data: 32'h1234_5678, err: 1'b0});
        slv_q.push_back('{wait_n: 1, data: 32'hA5A5_0001, err: 1'b0});
        exp_resp.push_back('{who: 1, data: 32'h0, err: 1'b1, to: 1'b1});
        exp_resp.push_back('{who: 0, data: 32'hA5A5_0001, err: 1'b0, to: 1'b0});
        @(negedge clk);
        m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 32'h3000_0300; m0_pwdata = 32'h0;
        m0_pstrb = 4'hF; m0_pprot = 3'd0;
        wait_pready(1, 40, c);
        m1_psel = 1'b0;
        checks++;
        if (c + 1 != 10 || arb_timeout !== 1'b1 || m1_pslverr !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pulse got cyc=%0d to=%b err=%b expected cyc=10 to=1 err=1",
                     c + 1, arb_timeout, m1_pslverr);
        end
        // 20 stalled slave cycles minus the 8 spent in ACCESS, plus the completing cycle.
        while (d < 40) begin
            @(negedge clk);
            if (!s_psel) break;
            d++;
            checks++;
            if (s_penable !== 1'b1) begin
                errors++; $display("FAIL drain_hold got penable=%b expected 1", s_penable);
            end
        end
        checks++;
        if (d != 13) begin
            errors++; $display("FAIL drain_length got %0d expected 13", d);
        end
        wait_pready(0, 40, c);
        m0_psel = 1'b0;
        checks++;
        if (c != 4) begin
            errors++; $display("FAIL post_drain_latency got %0d expected 4", c);
        end
    endtask

    task automatic test_expiry_pready();
        int c;
        m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 32'h3000_0400; m0_pstrb = 4'hF; m0_pprot = 3'd0;
        exp_grant.push_back('{32'h3000_0400, 1'b0, 32'h0, 4'hF, 3'd0});
        slv_q.push_back('{wait_n: 7, data: 32'h0BAD_F00D, err: 1'b0});
        exp_resp.push_back('{who: 0, data: 32'h0BAD_F00D, err: 1'b0, to: 1'b0});
        wait_pready(0, 40, c);
        m0_psel = 1'b0;
        checks++;
        if (c != 10 || arb_timeout !== 1'b0 || m0_pslverr !== 1'b0) begin
            errors++;
            $display("FAIL expiry_pready got cyc=%0d to=%b err=%b expected cyc=10 to=0 err=0",
                     c, arb_timeout, m0_pslverr);
        end
    endtask

    task automatic test_drop_psel();
        int c;
        int k = 0;
        m1_psel = 1'b1; m1_pwrite = 1'b0; m1_paddr = 32'h1000_0010; m1_pstrb = 4'hF; m1_pprot = 3'd4;
        exp_grant.push_back('{32'h1000_0010, 1'b0, 32'hCAFE_F00D, 4'hF, 3'd4});
        slv_q.push_back('{wait_n: 2, data: 32'h7777_0000, err: 1'b1});
        exp_resp.push_back('{who: 1, data: 32'h7777_0000, err: 1'b1, to: 1'b0});
        do begin
            @(negedge clk);
            k++;
        end while (!s_penable && k < 20);
        m1_psel = 1'b0;
        wait_pready(1, 20, c);
        checks++;
        if (c != 3 || m1_pready !== 1'b1) begin
            errors++; $display("FAIL drop_psel got cyc=%0d pready=%b expected cyc=3 pready=1", c, m1_pready);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        int k = 0;
        m0_psel = 1'b1; m0_pwrite = 1'b0; m0_paddr = 32'h3000_0500; m0_pstrb = 4'hF; m0_pprot = 3'd0;
        exp_grant.push_back('{32'h3000_0500, 1'b0, 32'h0, 4'hF, 3'd0});
        slv_q.push_back('{wait_n: 20, data: 32'hBAD0_BAD0, err: 1'b0});
        do begin
            @(negedge clk);
            k++;
        end while (!s_penable && k < 20);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({m0_pready, m0_pslverr, m0_prdata, m1_pready, m1_pslverr, m1_prdata, arb_timeout,
             s_psel, s_penable, s_pwrite, s_paddr, s_pwdata, s_pstrb, s_pprot} !== 143'd0) begin
            errors++;
            $display("FAIL async_reset got psel=%b pen=%b addr=%h expected all outputs 0",
                     s_psel, s_penable, s_paddr);
        end
        m0_psel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m1_psel = 1'b1; m1_pwrite = 1'b1; m1_paddr = 32'h1000_0020; m1_pwdata = 32'h0F0F_0F0F;
        m1_pstrb = 4'hC; m1_pprot = 3'd5;
        exp_grant.push_back('{32'h1000_0020, 1'b1, 32'h0F0F_0F0F, 4'hC, 3'd5});
        slv_q.push_back('{wait_n: 1, data: 32'h0, err: 1'b0});
        exp_resp.push_back('{who: 1, data: 32'h0, err: 1'b0, to: 1'b0});
        wait_pready(1, 40, c);
        m1_psel = 1'b0;
        checks++;
        if (c != 4) begin
            errors++; $display("FAIL post_reset_latency got %0d expected 4", c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        repeat (2) @(negedge clk);
        test_single_read();
        repeat (2) @(negedge clk);
        test_back_to_back();
        repeat (2) @(negedge clk);
        test_timeout();
        repeat (2) @(negedge clk);
        test_expiry_pready();
        repeat (2) @(negedge clk);
        test_drop_psel();
        repeat (2) @(negedge clk);
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_grant.size() != 0 || exp_resp.size() != 0 || slv_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained got grant=%0d resp=%0d slave=%0d expected 0 0 0",
                     exp_grant.size(), exp_resp.size(), slv_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
